autoconfig_master: RTL and testbench
====================================

AUTOCONFIG_MASTER -- requirements
Module: autoconfig_master

Interface
REQ-001 SHALL have parameter FAST_RAM_BASE, default 8'h20, meaning the Zorro II base (address bits 23:16) assigned to the board.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the CPU_CLK cycles to wait for DTACK before abort.
REQ-003 CPU_CLK  in  1  sole clock; all state changes on posedge.
REQ-004 RESET_n  in  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 START  in  1  one-cycle request to configure the board at $E8xxxx.
REQ-006 ADDRESS  out  23  bus address [23:1].
REQ-007 AS_n  out  1  address strobe.
REQ-008 UDS_n  out  1  upper data strobe.
REQ-009 LDS_n  out  1  lower data strobe; held 1.
REQ-010 RW  out  1  1=read, 0=write.
REQ-011 DTACK_n  in  1  transfer acknowledge from the responder.
REQ-012 DATA_IN  in  4  read nibble, bus DATA[15:12].
REQ-013 DATA_OUT  out  4  write nibble for DATA[15:12].
REQ-014 DATA_OE  out  1  drive enable for DATA_OUT.
REQ-015 BUSY  out  1  sequence in progress.
REQ-016 DONE  out  1  one-cycle completion pulse.
REQ-017 CONFIGURED  out  1  board assigned FAST_RAM_BASE.
REQ-018 ERROR  out  1  DTACK timeout occurred.
REQ-019 BOARD_SIZE  out  3  er_Type size code.
REQ-020 BOARD_PRODUCT  out  8  decoded product number.

Function
REQ-021 Bus-cycle FSM SHALL be IDLE -> ADDR -> STROBE -> WAIT -> LATCH -> NEGATE -> (next step or FINISH) -> IDLE, one state per clock except WAIT.
REQ-022 ADDR: drive ADDRESS = {8'hE8, 8'h00, offset[7:1]}, set RW; for writes assert DATA_OE and drive DATA_OUT. AS_n and UDS_n stay 1.
REQ-023 STROBE: AS_n=0, UDS_n=0; clear timeout counter.
REQ-024 WAIT: stay while DTACK_n=1; on DTACK_n=0 go to LATCH next clock.
REQ-025 LATCH: for reads, capture DATA_IN into the step register. AS_n and UDS_n stay 0.
REQ-026 NEGATE: AS_n=1, UDS_n=1. Drop DATA_OE. ADDRESS and RW held one more cycle.
REQ-027 Step sequence: read $00, read $02, read $04, read $06, then either write $4A then write $48, or write $4C.
REQ-028 Bytes $00/$02 SHALL be used uninverted; $04/$06 SHALL be inverted: BOARD_PRODUCT = ~{n04,n06}.
REQ-029 After $02 is read, er_Type = {n00,n02}; BOARD_SIZE = er_Type[2:0].
REQ-030 Configure path: if er_Type[7:6]==2'b11 and er_Type[5]==1, write $4A with FAST_RAM_BASE[3:0] first, then $48 with FAST_RAM_BASE[7:4]. Set CONFIGURED=1 after the $48 cycle's NEGATE.
REQ-031 Shut-up path: otherwise, write $4C with data 4'h0. CONFIGURED stays 0.
REQ-032 Timeout: if WAIT persists TIMEOUT cycles, go to NEGATE, set ERROR=1, then FINISH; skip the remaining steps.
REQ-033 FINISH: DONE=1 for one cycle, BUSY=0 next; results held until the next START.
REQ-034 START in IDLE SHALL clear ERROR, CONFIGURED, BOARD_SIZE, BOARD_PRODUCT and set BUSY the same edge. START while BUSY SHALL be ignored.
REQ-035 DTACK_n low in any state other than WAIT SHALL be ignored.

Reset
REQ-036 RESET_n=0 SHALL immediately force IDLE, AS_n=UDS_n=LDS_n=RW=1, DATA_OE=0, ADDRESS=0, DATA_OUT=0, BUSY=DONE=CONFIGURED=ERROR=0, BOARD_SIZE=0, BOARD_PRODUCT=0.
REQ-037 Reset mid-cycle SHALL release the strobes asynchronously. No write SHALL be reissued after reset until a new START.

Verification
REQ-038 Responder returns E,5,9,8 with DTACK after 2 cycles -> writes $4A=0 then $48=2, CONFIGURED=1, BOARD_SIZE=3'b101, BOARD_PRODUCT=8'h67, DONE pulse, ERROR=0.
REQ-039 Responder returns $00 nibble 8 (type 10) -> after 4 reads, single write $4C=0, CONFIGURED=0, DONE pulse.
REQ-040 Responder never asserts DTACK -> AS_n negates after 64 WAIT cycles, ERROR=1, DONE pulse, no write cycles.
REQ-041 RESET_n pulled low during STROBE of the $48 write -> AS_n=1 and DATA_OE=0 immediately, CONFIGURED=0, no further cycles.
REQ-042 START pulsed again mid-sequence and DTACK_n held low before STROBE -> the sequence is unchanged, and WAIT exits only after STROBE.

Source files
------------

// File: rtl/autoconfig_master.sv
// Purpose : Zorro II autoconfig master; reads the board ID nibbles at $E8xxxx and
//           either assigns FAST_RAM_BASE to the board or shuts it up.
// Latency : ADDR/STROBE/WAIT/LATCH/NEGATE per bus cycle; WAIT lasts until DTACK_n or TIMEOUT.
// Backpressure: the responder stalls the sequence through DTACK_n; START is ignored while BUSY.
//
// Ports:
//   CPU_CLK, RESET_n          clock, async active-low reset
//   START                     one-cycle request to run the configure sequence
//   ADDRESS[23:1], AS_n, UDS_n, LDS_n, RW, DATA_OUT, DATA_OE   bus master outputs
//   DTACK_n, DATA_IN          responder acknowledge and read nibble (DATA[15:12])
//   BUSY, DONE, CONFIGURED, ERROR, BOARD_SIZE, BOARD_PRODUCT   status/results
module autoconfig_master #(
  parameter logic [7:0] FAST_RAM_BASE = 8'h20,
  parameter int         TIMEOUT       = 64
) (
  input  logic        CPU_CLK,
  input  logic        RESET_n,
  input  logic        START,
  output logic [22:0] ADDRESS,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW,
  input  logic        DTACK_n,
  input  logic [3:0]  DATA_IN,
  output logic [3:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        CONFIGURED,
  output logic        ERROR,
  output logic [2:0]  BOARD_SIZE,
  output logic [7:0]  BOARD_PRODUCT
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_STROBE, ST_WAIT, ST_LATCH, ST_NEGATE, ST_FINISH
  } state_t;

  typedef enum logic [2:0] {
    STEP_00, STEP_02, STEP_04, STEP_06, STEP_4A, STEP_48, STEP_4C
  } step_t;

  state_t        r_state, w_next_state;
  step_t         r_step,  w_next_step;
  logic [TW-1:0] r_tmo;
  logic [2:0]    r_n00_hi;     // er_Type[7:5] as read from $00
  logic [3:0]    r_n04;
  logic          r_cfg_ok;     // board is Zorro II memory that wants a base address
  logic          r_configured;
  logic          r_error;
  logic [2:0]    r_size;
  logic [7:0]    r_product;

  logic [6:0]    w_word;       // register offset expressed as a word address (offset[7:1])
  logic          w_is_read;
  logic [3:0]    w_wr_dat;
  logic          w_bus;
  logic          w_strobe;
  logic          w_timeout;

  // Step decode: word address, direction and write nibble of the current bus cycle.
  always_comb begin
    w_word    = 7'h00;
    w_is_read = 1'b1;
    w_wr_dat  = 4'h0;
    case (r_step)
      STEP_00: w_word = 7'h00;
      STEP_02: w_word = 7'h01;
      STEP_04: w_word = 7'h02;
      STEP_06: w_word = 7'h03;
      STEP_4A: begin w_word = 7'h25; w_is_read = 1'b0; w_wr_dat = FAST_RAM_BASE[3:0]; end
      STEP_48: begin w_word = 7'h24; w_is_read = 1'b0; w_wr_dat = FAST_RAM_BASE[7:4]; end
      STEP_4C: begin w_word = 7'h26; w_is_read = 1'b0; w_wr_dat = 4'h0; end
      default: w_word = 7'h00;
    endcase
  end

  assign w_timeout = (r_state == ST_WAIT) && DTACK_n && (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge CPU_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_00;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
    end
  end

  // Next state plus all bus outputs; outputs decode from state so an async reset
  // releases the strobes and data drive without waiting for a clock.
  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_next_state = ST_ADDR;
          w_next_step  = STEP_00;
        end
      end
      ST_ADDR:   w_next_state = ST_STROBE;
      ST_STROBE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (!DTACK_n)       w_next_state = ST_LATCH;
        else if (w_timeout) w_next_state = ST_NEGATE;
      end
      ST_LATCH: w_next_state = ST_NEGATE;
      ST_NEGATE: begin
        if (r_error || r_step == STEP_48 || r_step == STEP_4C) begin
          w_next_state = ST_FINISH;
        end else begin
          w_next_state = ST_ADDR;
          case (r_step)
            STEP_00: w_next_step = STEP_02;
            STEP_02: w_next_step = STEP_04;
            STEP_04: w_next_step = STEP_06;
            STEP_06: w_next_step = r_cfg_ok ? STEP_4A : STEP_4C;
            STEP_4A: w_next_step = STEP_48;
            default: w_next_step = r_step;
          endcase
        end
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  assign w_bus    = (r_state == ST_ADDR) || (r_state == ST_STROBE) || (r_state == ST_WAIT) ||
                    (r_state == ST_LATCH) || (r_state == ST_NEGATE);
  assign w_strobe = (r_state == ST_STROBE) || (r_state == ST_WAIT) || (r_state == ST_LATCH);

  // ADDRESS and RW stay valid through NEGATE; data drive drops at NEGATE.
  assign ADDRESS  = w_bus ? {8'hE8, 8'h00, w_word} : 23'h0;
  assign RW       = w_bus ? w_is_read : 1'b1;
  assign AS_n     = ~w_strobe;
  assign UDS_n    = ~w_strobe;
  assign LDS_n    = 1'b1;
  assign DATA_OE  = ~w_is_read && w_bus && (r_state != ST_NEGATE);
  assign DATA_OUT = DATA_OE ? w_wr_dat : 4'h0;
  assign BUSY     = (r_state != ST_IDLE);
  assign DONE     = (r_state == ST_FINISH);

  always_ff @(posedge CPU_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_tmo        <= '0;
      r_n00_hi     <= 3'h0;
      r_n04        <= 4'h0;
      r_cfg_ok     <= 1'b0;
      r_configured <= 1'b0;
      r_error      <= 1'b0;
      r_size       <= 3'h0;
      r_product    <= 8'h0;
    end else begin
      if (r_state == ST_IDLE && START) begin
        r_n00_hi     <= 3'h0;
        r_n04        <= 4'h0;
        r_cfg_ok     <= 1'b0;
        r_configured <= 1'b0;
        r_error      <= 1'b0;
        r_size       <= 3'h0;
        r_product    <= 8'h0;
      end
      if (r_state == ST_STROBE) r_tmo <= '0;
      if (r_state == ST_WAIT)   r_tmo <= r_tmo + TW'(1);
      if (w_timeout)            r_error <= 1'b1;
      if (r_state == ST_LATCH && w_is_read) begin
        case (r_step)
          STEP_00: r_n00_hi <= DATA_IN[3:1];
          STEP_02: begin
            // er_Type = {n00, n02}: bits 7:5 come from $00, size code from $02.
            r_size   <= DATA_IN[2:0];
            r_cfg_ok <= (r_n00_hi == 3'b111);
          end
          STEP_04: r_n04 <= DATA_IN;
          STEP_06: r_product <= ~{r_n04, DATA_IN};  // product nibbles are stored inverted
          default: r_n04 <= r_n04;
        endcase
      end
      if (r_state == ST_NEGATE && r_step == STEP_48 && !r_error) r_configured <= 1'b1;
    end
  end

  assign CONFIGURED    = r_configured;
  assign ERROR         = r_error;
  assign BOARD_SIZE    = r_size;
  assign BOARD_PRODUCT = r_product;

endmodule

// File: tb/tb_autoconfig_master.sv
module tb_autoconfig_master;

  logic        CPU_CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        START   = 1'b0;
  logic        DTACK_n = 1'b1;
  logic [3:0]  DATA_IN = 4'h0;
  logic [22:0] ADDRESS;
  logic        AS_n, UDS_n, LDS_n, RW, DATA_OE, BUSY, DONE, CONFIGURED, ERROR;
  logic [3:0]  DATA_OUT;
  logic [2:0]  BOARD_SIZE;
  logic [7:0]  BOARD_PRODUCT;

  autoconfig_master #(.FAST_RAM_BASE(8'h20), .TIMEOUT(64)) dut (
    .CPU_CLK(CPU_CLK), .RESET_n(RESET_n), .START(START),
    .ADDRESS(ADDRESS), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
    .DTACK_n(DTACK_n), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .BUSY(BUSY), .DONE(DONE), .CONFIGURED(CONFIGURED), .ERROR(ERROR),
    .BOARD_SIZE(BOARD_SIZE), .BOARD_PRODUCT(BOARD_PRODUCT)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder: mode 0 = DTACK two cycles into the strobe, 1 = never, 2 = held low always.
  logic [3:0] tbl [0:3];
  int         mode = 0;
  int         rsp_cnt = 0;

  always @(negedge CPU_CLK) begin
    DATA_IN = tbl[ADDRESS[1:0]];
    case (mode)
      0: begin
        if (!AS_n) begin
          rsp_cnt = rsp_cnt + 1;
          DTACK_n = (rsp_cnt >= 2) ? 1'b0 : 1'b1;
        end else begin
          rsp_cnt = 0;
          DTACK_n = 1'b1;
        end
      end
      1: DTACK_n = 1'b1;
      default: DTACK_n = 1'b0;
    endcase
  end

  // Bus monitor: monotonic counters, tests take before/after snapshots.
  int          rd_cnt = 0, wr_cnt = 0, as_low = 0, short_runs = 0, done_cnt = 0, cur_run = 0;
  logic        prev_as = 1'b1;
  logic [22:0] wr_addr [0:63];
  logic [3:0]  wr_data [0:63];
  logic        wr_oe   [0:63];

  always @(negedge CPU_CLK) begin
    if (prev_as && !AS_n) begin
      if (RW) rd_cnt = rd_cnt + 1;
      else begin
        wr_addr[wr_cnt % 64] = ADDRESS;
        wr_data[wr_cnt % 64] = DATA_OUT;
        wr_oe[wr_cnt % 64]   = DATA_OE;
        wr_cnt = wr_cnt + 1;
      end
    end
    if (!AS_n) begin
      as_low  = as_low + 1;
      cur_run = cur_run + 1;
    end else begin
      if (cur_run > 0 && cur_run < 3) short_runs = short_runs + 1;
      cur_run = 0;
    end
    if (DONE === 1'b1) done_cnt = done_cnt + 1;
    prev_as = AS_n;
  end

  task automatic set_tbl(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
  endtask

  // Pulses START, optionally pulses it again restart_at cycles later, waits for DONE.
  task automatic run_start(input int restart_at, output bit ok, output bit busy_at_done,
                           output bit clean_after);
    ok = 0; busy_at_done = 0; clean_after = 0;
    @(negedge CPU_CLK); START = 1'b1;
    @(negedge CPU_CLK); START = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      START = (c == restart_at);
      if (DONE === 1'b1) begin
        ok = 1;
        busy_at_done = BUSY;
        break;
      end
      @(negedge CPU_CLK);
    end
    START = 1'b0;
    if (ok) begin
      @(negedge CPU_CLK);
      clean_after = (DONE === 1'b0) && (BUSY === 1'b0);
    end
  endtask

  task automatic test_reset;
    RESET_n = 1'b0;
    START   = 1'b0;
    repeat (3) @(negedge CPU_CLK);
    n_checks++;
    if ({AS_n, UDS_n, LDS_n, RW} !== 4'hF) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 1111", {AS_n, UDS_n, LDS_n, RW});
    end
    n_checks++;
    if ({DATA_OE, DATA_OUT, ADDRESS} !== 28'h0) begin
      n_fail++; $display("FAIL reset_bus: oe=%b dout=%h addr=%h expected all zero", DATA_OE, DATA_OUT, ADDRESS);
    end
    n_checks++;
    if ({BUSY, DONE, CONFIGURED, ERROR, BOARD_SIZE, BOARD_PRODUCT} !== 15'h0) begin
      n_fail++; $display("FAIL reset_status: busy=%b done=%b cfg=%b err=%b size=%h prod=%h expected all zero",
                         BUSY, DONE, CONFIGURED, ERROR, BOARD_SIZE, BOARD_PRODUCT);
    end
    RESET_n = 1'b1;
    repeat (2) @(negedge CPU_CLK);
    n_checks++;
    if (BUSY !== 1'b0 || AS_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: busy=%b as_n=%b expected 0 1", BUSY, AS_n);
    end
  endtask

  task automatic test_configure;
    int w0, r0, d0;
    bit ok, bad, clean;
    mode = 0; set_tbl(4'hE, 4'h5, 4'h9, 4'h8);
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    run_start(-1, ok, bad, clean);
    n_checks++;
    if (!ok || !bad || !clean) begin
      n_fail++; $display("FAIL cfg_done: done_seen=%0d busy_at_done=%0d clean_after=%0d expected 1 1 1", ok, bad, clean);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || rd_cnt - r0 != 4 || wr_cnt - w0 != 2) begin
      n_fail++; $display("FAIL cfg_counts: done=%0d reads=%0d writes=%0d expected 1 4 2", done_cnt - d0, rd_cnt - r0, wr_cnt - w0);
    end
    n_checks++;
    if (wr_addr[w0 % 64] !== 23'h740025 || wr_data[w0 % 64] !== 4'h0 || wr_oe[w0 % 64] !== 1'b1) begin
      n_fail++; $display("FAIL cfg_write4A: addr=%h data=%h oe=%b expected 740025 0 1",
                         wr_addr[w0 % 64], wr_data[w0 % 64], wr_oe[w0 % 64]);
    end
    n_checks++;
    if (wr_addr[(w0 + 1) % 64] !== 23'h740024 || wr_data[(w0 + 1) % 64] !== 4'h2 || wr_oe[(w0 + 1) % 64] !== 1'b1) begin
      n_fail++; $display("FAIL cfg_write48: addr=%h data=%h oe=%b expected 740024 2 1",
                         wr_addr[(w0 + 1) % 64], wr_data[(w0 + 1) % 64], wr_oe[(w0 + 1) % 64]);
    end
    n_checks++;
    if (CONFIGURED !== 1'b1 || ERROR !== 1'b0 || BOARD_SIZE !== 3'b101 || BOARD_PRODUCT !== 8'h67) begin
      n_fail++; $display("FAIL cfg_results: cfg=%b err=%b size=%b prod=%h expected 1 0 101 67",
                         CONFIGURED, ERROR, BOARD_SIZE, BOARD_PRODUCT);
    end
    repeat (5) @(negedge CPU_CLK);
    n_checks++;
    if (CONFIGURED !== 1'b1 || BOARD_PRODUCT !== 8'h67 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL cfg_hold: cfg=%b prod=%h busy=%b expected 1 67 0", CONFIGURED, BOARD_PRODUCT, BUSY);
    end
  endtask

  task automatic test_shutup;
    int w0, r0, d0;
    bit ok, bad, clean;
    mode = 0; set_tbl(4'h8, 4'h5, 4'h9, 4'h8);
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    run_start(-1, ok, bad, clean);
    n_checks++;
    if (!ok || !clean || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL shut_done: done_seen=%0d clean=%0d pulses=%0d expected 1 1 1", ok, clean, done_cnt - d0);
    end
    n_checks++;
    if (rd_cnt - r0 != 4 || wr_cnt - w0 != 1) begin
      n_fail++; $display("FAIL shut_counts: reads=%0d writes=%0d expected 4 1", rd_cnt - r0, wr_cnt - w0);
    end
    n_checks++;
    if (wr_addr[w0 % 64] !== 23'h740026 || wr_data[w0 % 64] !== 4'h0) begin
      n_fail++; $display("FAIL shut_write4C: addr=%h data=%h expected 740026 0", wr_addr[w0 % 64], wr_data[w0 % 64]);
    end
    n_checks++;
    if (CONFIGURED !== 1'b0 || ERROR !== 1'b0 || BOARD_SIZE !== 3'b101 || BOARD_PRODUCT !== 8'h67) begin
      n_fail++; $display("FAIL shut_results: cfg=%b err=%b size=%b prod=%h expected 0 0 101 67",
                         CONFIGURED, ERROR, BOARD_SIZE, BOARD_PRODUCT);
    end
  endtask

  task automatic test_timeout;
    int w0, r0, a0;
    bit ok, bad, clean;
    mode = 1; set_tbl(4'hE, 4'h5, 4'h9, 4'h8);
    w0 = wr_cnt; r0 = rd_cnt; a0 = as_low;
    run_start(-1, ok, bad, clean);
    n_checks++;
    if (!ok || !clean) begin
      n_fail++; $display("FAIL tmo_done: done_seen=%0d clean=%0d expected 1 1", ok, clean);
    end
    n_checks++;
    if (as_low - a0 != 65) begin
      n_fail++; $display("FAIL tmo_strobe_len: as_n low %0d cycles expected 65", as_low - a0);
    end
    n_checks++;
    if (rd_cnt - r0 != 1 || wr_cnt - w0 != 0) begin
      n_fail++; $display("FAIL tmo_counts: reads=%0d writes=%0d expected 1 0", rd_cnt - r0, wr_cnt - w0);
    end
    n_checks++;
    if (ERROR !== 1'b1 || CONFIGURED !== 1'b0 || BOARD_SIZE !== 3'h0 || BOARD_PRODUCT !== 8'h0) begin
      n_fail++; $display("FAIL tmo_results: err=%b cfg=%b size=%h prod=%h expected 1 0 0 00",
                         ERROR, CONFIGURED, BOARD_SIZE, BOARD_PRODUCT);
    end
  endtask

  task automatic test_reset_mid;
    int w0, a0;
    bit found;
    mode = 0; set_tbl(4'hE, 4'h5, 4'h9, 4'h8);
    w0 = wr_cnt; found = 0;
    @(negedge CPU_CLK); START = 1'b1;
    @(negedge CPU_CLK); START = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (AS_n === 1'b1 && DATA_OE === 1'b1 && ADDRESS === 23'h740024) begin
        found = 1;
        break;
      end
      @(negedge CPU_CLK);
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rmid_reach48: write $48 address phase seen=%0d expected 1", found);
    end
    @(posedge CPU_CLK); #1;
    n_checks++;
    if (AS_n !== 1'b0 || DATA_OE !== 1'b1) begin
      n_fail++; $display("FAIL rmid_strobe: as_n=%b oe=%b expected 0 1", AS_n, DATA_OE);
    end
    RESET_n = 1'b0;
    #1;
    n_checks++;
    if (AS_n !== 1'b1 || UDS_n !== 1'b1 || DATA_OE !== 1'b0 || CONFIGURED !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: as_n=%b uds_n=%b oe=%b cfg=%b busy=%b expected 1 1 0 0 0",
                         AS_n, UDS_n, DATA_OE, CONFIGURED, BUSY);
    end
    @(negedge CPU_CLK); RESET_n = 1'b1;
    a0 = as_low;
    repeat (20) @(negedge CPU_CLK);
    n_checks++;
    if (as_low - a0 != 0 || wr_cnt - w0 != 1 || CONFIGURED !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rmid_quiet: strobe_cycles=%0d writes=%0d cfg=%b busy=%b expected 0 1 0 0",
                         as_low - a0, wr_cnt - w0, CONFIGURED, BUSY);
    end
  endtask

  task automatic test_early_dtack_restart;
    int w0, r0, a0, s0, d0;
    bit ok, bad, clean;
    mode = 2; set_tbl(4'hE, 4'h5, 4'h9, 4'h8);
    w0 = wr_cnt; r0 = rd_cnt; a0 = as_low; s0 = short_runs; d0 = done_cnt;
    run_start(7, ok, bad, clean);
    n_checks++;
    if (!ok || !clean || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL early_done: done_seen=%0d clean=%0d pulses=%0d expected 1 1 1", ok, clean, done_cnt - d0);
    end
    n_checks++;
    if (rd_cnt - r0 != 4 || wr_cnt - w0 != 2) begin
      n_fail++; $display("FAIL early_counts: reads=%0d writes=%0d expected 4 2", rd_cnt - r0, wr_cnt - w0);
    end
    n_checks++;
    if (as_low - a0 != 18 || short_runs - s0 != 0) begin
      n_fail++; $display("FAIL early_strobe_len: low_cycles=%0d short_cycles=%0d expected 18 0", as_low - a0, short_runs - s0);
    end
    n_checks++;
    if (wr_addr[(w0 + 1) % 64] !== 23'h740024 || wr_data[(w0 + 1) % 64] !== 4'h2 || CONFIGURED !== 1'b1) begin
      n_fail++; $display("FAIL early_result: addr=%h data=%h cfg=%b expected 740024 2 1",
                         wr_addr[(w0 + 1) % 64], wr_data[(w0 + 1) % 64], CONFIGURED);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    set_tbl(4'h0, 4'h0, 4'h0, 4'h0);
    test_reset();
    test_configure();
    test_shutup();
    test_timeout();
    test_reset_mid();
    test_early_dtack_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
